// File: rtl/cond_writeback_stage.sv
// rtl/cond_writeback_stage.sv - ARM-style condition check, NZCV update and registered writeback stage
//
// Purpose:
//   One-deep valid/ready register behind the alu. It evaluates the 4-bit condition
//   field against the architectural NZCV register as it stood before this
//   instruction. It updates NZCV under FlagW when the condition passes. It gates
//   PCSrc/RegWrite/MemWrite with the condition. It counts squashed instructions
//   in a saturating counter.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   upstream handshake (in_ready is combinational)
//   Cond, ALUFlags      condition field and {N,Z,C,V} produced by the alu
//   Result              alu result, registered into ResultOut
//   FlagW               [1] write N,Z  [0] write C,V
//   PCS, RegW, MemW     raw write intents, gated into PCSrc/RegWrite/MemWrite
//   out_valid/out_ready downstream handshake
//   ResultOut, CondEx   registered result and condition-pass
//   PCSrc, RegWrite,    registered, condition-gated write enables
//   MemWrite
//   Flags               architectural {N,Z,C,V}
//   SkipCount           saturating count of accepted condition-failed instructions

module cond_writeback_stage #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [WIDTH-1:0] Result,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             RegW,
  input  logic             MemW,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ResultOut,
  output logic             CondEx,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic [3:0]       Flags,
  output logic [CNT_W-1:0] SkipCount
);

  logic n, z, c, v;
  logic cond_pass;
  logic accept;

  assign {n, z, c, v} = Flags;

  // Evaluated against the current register, so an instruction never sees its own flag update.
  always_comb begin
    cond_pass = 1'b0;
    case (Cond)
      4'b0000: cond_pass = z;
      4'b0001: cond_pass = !z;
      4'b0010: cond_pass = c;
      4'b0011: cond_pass = !c;
      4'b0100: cond_pass = n;
      4'b0101: cond_pass = !n;
      4'b0110: cond_pass = v;
      4'b0111: cond_pass = !v;
      4'b1000: cond_pass = c & !z;
      4'b1001: cond_pass = !c | z;
      4'b1010: cond_pass = (n == v);
      4'b1011: cond_pass = (n != v);
      4'b1100: cond_pass = !z & (n == v);
      4'b1101: cond_pass = z | (n != v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  assign in_ready = !out_valid | out_ready;
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      ResultOut <= '0;
      CondEx    <= 1'b0;
      PCSrc     <= 1'b0;
      RegWrite  <= 1'b0;
      MemWrite  <= 1'b0;
      Flags     <= 4'b0000;
      SkipCount <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      // ResultOut loads even on a squashed instruction; the gated enables make it harmless.
      ResultOut <= Result;
      CondEx    <= cond_pass;
      PCSrc     <= PCS & cond_pass;
      RegWrite  <= RegW & cond_pass;
      MemWrite  <= MemW & cond_pass;
      if (cond_pass && FlagW[1]) Flags[3:2] <= ALUFlags[3:2];
      if (cond_pass && FlagW[0]) Flags[1:0] <= ALUFlags[1:0];
      if (!cond_pass && (SkipCount != {CNT_W{1'b1}}))
        SkipCount <= SkipCount + CNT_W'(1);
    end else if (out_ready) begin
      // Slot drained with nothing behind it; data outputs keep their last value.
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cond_writeback_stage.sv
// tb/tb_cond_writeback_stage.sv - scoreboard bench for cond_writeback_stage

module tb_cond_writeback_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [3:0]  Cond;
  logic [3:0]  ALUFlags;
  logic [31:0] Result;
  logic [1:0]  FlagW;
  logic        PCS, RegW, MemW;
  logic        out_ready;

  logic        in_ready, out_valid, CondEx, PCSrc, RegWrite, MemWrite;
  logic [31:0] ResultOut;
  logic [3:0]  Flags;
  logic [7:0]  SkipCount;

  logic        in_ready_b, out_valid_b, CondEx_b, PCSrc_b, RegWrite_b, MemWrite_b;
  logic [31:0] ResultOut_b;
  logic [3:0]  Flags_b;
  logic [1:0]  SkipCount_b;

  always #5 clk = ~clk;

  cond_writeback_stage #(.WIDTH(32), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .Cond(Cond), .ALUFlags(ALUFlags), .Result(Result), .FlagW(FlagW),
    .PCS(PCS), .RegW(RegW), .MemW(MemW), .out_valid(out_valid), .out_ready(out_ready),
    .ResultOut(ResultOut), .CondEx(CondEx), .PCSrc(PCSrc), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .Flags(Flags), .SkipCount(SkipCount)
  );

  cond_writeback_stage #(.WIDTH(32), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
    .Cond(Cond), .ALUFlags(ALUFlags), .Result(Result), .FlagW(FlagW),
    .PCS(PCS), .RegW(RegW), .MemW(MemW), .out_valid(out_valid_b), .out_ready(out_ready),
    .ResultOut(ResultOut_b), .CondEx(CondEx_b), .PCSrc(PCSrc_b), .RegWrite(RegWrite_b),
    .MemWrite(MemWrite_b), .Flags(Flags_b), .SkipCount(SkipCount_b)
  );

  typedef struct packed {
    logic [31:0] res;
    logic        cx, pc, rw, mw;
    logic [3:0]  fl;
    logic [7:0]  sk8;
    logic [1:0]  sk2;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference state: architectural flags, total skips, whether the output slot is occupied.
  bit mN, mZ, mC, mV;
  int skips;
  bit occ;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit passes(input logic [3:0] cc);
    case (cc)
      4'd0:  return mZ;
      4'd1:  return !mZ;
      4'd2:  return mC;
      4'd3:  return !mC;
      4'd4:  return mN;
      4'd5:  return !mN;
      4'd6:  return mV;
      4'd7:  return !mV;
      4'd8:  return mC && !mZ;
      4'd9:  return !mC || mZ;
      4'd10: return mN == mV;
      4'd11: return mN != mV;
      4'd12: return !mZ && (mN == mV);
      4'd13: return mZ || (mN != mV);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic step(input bit v, input logic [3:0] c, input logic [3:0] af,
                      input logic [31:0] r, input logic [1:0] fw,
                      input bit pcs, input bit rw, input bit mw, input bit ordy);
    bit   rdy, p;
    exp_t e;
    @(posedge clk); #1;
    in_valid = v; Cond = c; ALUFlags = af; Result = r; FlagW = fw;
    PCS = pcs; RegW = rw; MemW = mw; out_ready = ordy;
    @(negedge clk);
    rdy = !occ || ordy;
    chk("in_ready", {63'd0, in_ready}, {63'd0, rdy});
    if (v && rdy) begin
      p = passes(c);
      if (p && fw[1]) begin mN = af[3]; mZ = af[2]; end
      if (p && fw[0]) begin mC = af[1]; mV = af[0]; end
      if (!p) skips++;
      e.res = r;
      e.cx  = p;
      e.pc  = pcs && p;
      e.rw  = rw && p;
      e.mw  = mw && p;
      e.fl  = {mN, mZ, mC, mV};
      e.sk8 = (skips > 255) ? 8'd255 : 8'(skips);
      e.sk2 = (skips > 3) ? 2'd3 : 2'(skips);
      q.push_back(e);
      occ = 1'b1;
    end else if (ordy) begin
      occ = 1'b0;
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
    chk({tag, "_in_ready"},  {63'd0, in_ready}, 64'd1);
    chk({tag, "_ResultOut"}, {32'd0, ResultOut}, 64'd0);
    chk({tag, "_enables"},   {60'd0, CondEx, PCSrc, RegWrite, MemWrite}, 64'd0);
    chk({tag, "_Flags"},     {60'd0, Flags}, 64'd0);
    chk({tag, "_SkipCount"}, {54'd0, SkipCount, SkipCount_b}, 64'd0);
  endtask

  task automatic model_reset();
    q.delete();
    {mN, mZ, mC, mV} = 4'b0000;
    skips = 0;
    occ   = 1'b0;
  endtask

  // Monitor: whenever the DUT presents data, compare against the head; pop on handshake.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_out_valid", 64'd1, 64'd0);
      end else begin
        chk("ResultOut",   {32'd0, ResultOut}, {32'd0, q[0].res});
        chk("CondEx",      {63'd0, CondEx},    {63'd0, q[0].cx});
        chk("PCSrc",       {63'd0, PCSrc},     {63'd0, q[0].pc});
        chk("RegWrite",    {63'd0, RegWrite},  {63'd0, q[0].rw});
        chk("MemWrite",    {63'd0, MemWrite},  {63'd0, q[0].mw});
        chk("Flags",       {60'd0, Flags},     {60'd0, q[0].fl});
        chk("SkipCount",   {56'd0, SkipCount}, {56'd0, q[0].sk8});
        chk("SkipCount_b", {62'd0, SkipCount_b}, {62'd0, q[0].sk2});
        chk("out_valid_b", {63'd0, out_valid_b}, 64'd1);
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    Cond = 4'd0; ALUFlags = 4'd0; Result = 32'd0; FlagW = 2'd0;
    PCS = 1'b0; RegW = 1'b0; MemW = 1'b0;
    model_reset();
    #12;
    check_reset_state("por");
    @(negedge clk); reset = 1'b0;

    // Set flags to 0110, then EQ passes and NE is squashed.
    step(1, 4'b1110, 4'b0110, 32'd0,         2'b11, 0, 0, 0, 1);
    step(1, 4'b0000, 4'b0000, 32'h1111_0000, 2'b00, 0, 1, 0, 1);
    step(1, 4'b0001, 4'b0000, 32'h2222_0000, 2'b00, 1, 1, 1, 1);
    // Partial flag write from 0110, then GE against the new flags.
    step(1, 4'b1110, 4'b1001, 32'h3333_0000, 2'b10, 0, 0, 0, 1);
    step(1, 4'b1010, 4'b0000, 32'h4444_0000, 2'b00, 1, 1, 1, 1);
    // Back-to-back: GT depends on the flags written by the instruction just ahead.
    step(1, 4'b1110, 4'b0000, 32'h5555_0000, 2'b11, 0, 0, 0, 1);
    step(1, 4'b1100, 4'b0000, 32'h6666_0000, 2'b00, 1, 0, 1, 1);
    // Stall for three cycles with in_valid held, then release.
    step(1, 4'b1110, 4'b1010, 32'hAAAA_0001, 2'b11, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++)
      step(1, 4'b1110, 4'b0101, 32'hBBBB_0002, 2'b11, 1, 1, 1, 0);
    step(1, 4'b1110, 4'b0101, 32'hBBBB_0002, 2'b11, 1, 1, 1, 1);
    step(0, 4'b0000, 4'b0000, 32'd0, 2'b00, 0, 0, 0, 1);

    // Reset in the middle of a stall with data held.
    step(1, 4'b1110, 4'b1111, 32'hDEAD_BEEF, 2'b11, 1, 1, 1, 0);
    step(0, 4'b0000, 4'b0000, 32'd0, 2'b00, 0, 0, 0, 0);
    @(posedge clk); #3;
    in_valid = 1'b0; reset = 1'b1;
    #1;
    check_reset_state("mid_stall");
    model_reset();
    @(negedge clk); reset = 1'b0;

    // Flags 0000: EQ fails and its flag write is suppressed; more fails saturate the narrow counter.
    step(1, 4'b0000, 4'b1111, 32'h0000_0C0C, 2'b11, 1, 1, 1, 1);
    for (int i = 0; i < 4; i++)
      step(1, 4'b1111, 4'b1111, 32'h0000_F000 + i, 2'b11, 1, 1, 1, 1);

    for (int i = 0; i < 1500; i++)
      step(($urandom % 4) != 0, 4'($urandom), 4'($urandom), $urandom, 2'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom), ($urandom % 4) != 0);

    for (int i = 0; i < 4; i++)
      step(0, 4'b0000, 4'b0000, 32'd0, 2'b00, 0, 0, 0, 1);
    chk("queue_drained", 64'(q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
